// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit: one shift-add or restoring-divide step per clock.
// Results land in hi/lo with a one-cycle done pulse.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  logic               busy_q, done_q, dbz_q;
  logic               div_q, neg_q, sa_q;
  logic [WIDTH-1:0]   b_q, hi_q, lo_q;
  logic [2*WIDTH-1:0] p_q, p_step, res;

  logic               sgn_a, sgn_b;
  logic [WIDTH-1:0]   mag_a, mag_b, addend;
  logic [WIDTH:0]     msum, top, diff;
  logic [2*WIDTH:0]   sh;

  always_comb begin
    sgn_a = ~op[0] & operand_a[WIDTH-1];
    sgn_b = ~op[0] & operand_b[WIDTH-1];
    mag_a = sgn_a ? -operand_a : operand_a;
    mag_b = sgn_b ? -operand_b : operand_b;
  end

  // p_q holds {partial, multiplier} for multiply, {remainder, quotient} for divide
  always_comb begin
    addend = p_q[0] ? b_q : {WIDTH{1'b0}};
    msum   = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    sh     = {p_q, 1'b0};
    top    = sh[2*WIDTH:WIDTH];
    diff   = top - {1'b0, b_q};
    if (!div_q)
      p_step = {msum, p_q[WIDTH-1:1]};
    else if (!diff[WIDTH])
      p_step = {diff[WIDTH-1:0], sh[WIDTH-1:1], 1'b1};
    else
      p_step = sh[2*WIDTH-1:0];
  end

  always_comb begin
    res = p_step;
    if (!div_q) begin
      if (neg_q) res = -p_step;
    end else begin
      res[WIDTH-1:0] = neg_q ? -p_step[WIDTH-1:0]
                             : p_step[WIDTH-1:0];
      res[2*WIDTH-1:WIDTH] = sa_q ? -p_step[2*WIDTH-1:WIDTH]
                                  : p_step[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      sa_q    <= 1'b0;
      b_q     <= '0;
      p_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
          if (start) begin
            div_q <= op[1];
            neg_q <= sgn_a ^ sgn_b;
            sa_q  <= sgn_a;
            b_q   <= mag_b;
            p_q   <= {{WIDTH{1'b0}}, mag_a};
            cnt_q <= '0;
            if (op[1] && operand_b == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              dbz_q   <= 1'b1;
              hi_q    <= operand_a;
              lo_q    <= '1;
            end else begin
              state_q <= RUN;
              busy_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          p_q   <= p_step;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            dbz_q   <= 1'b0;
            hi_q    <= res[2*WIDTH-1:WIDTH];
            lo_q    <= res[WIDTH-1:0];
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule
